// File: rtl/down_timer_pkg.sv
// Shared types and default sizes for the down_timer block.
//   timer_state_e  : control FSM encoding (IDLE / RUN / HOLD)
//   DEF_WIDTH      : default width of load value, reload register and count
//   DEF_PRESCALE_W : default prescaler compare width
package down_timer_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } timer_state_e;

endpackage : down_timer_pkg

// File: rtl/down_timer_prescaler.sv
// Tick prescaler: passes one tick_en out of every (prescale+1) while running.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   run          : counting allowed this cycle (timer in RUN and not halted)
//   clear        : force the internal counter back to zero
//   tick_en      : raw tick enable
//   prescale     : compare value; 0 passes every tick
//   tick_out     : effective tick (combinational from counter and inputs)
module down_timer_prescaler
  import down_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic                  tick_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick_out
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  assign tick_out = run && tick_en && (pcnt_q == prescale);

  // Counter sits at zero outside RUN, so any exit from RUN also clears it.
  always_comb begin
    pcnt_d = pcnt_q;
    if (!run || clear || tick_out) begin
      pcnt_d = '0;
    end else if (tick_en) begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule : down_timer_prescaler

// File: rtl/down_timer.sv
// Programmable down-counting timer with load handshake, halt/resume and
// optional auto-reload on expiry.
// Optional feature macro: DOWN_TIMER_PRESCALE_EN adds a 'prescale' input and
// a prescaler so that only every (prescale+1)th tick_en is counted.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   load_valid/load_value   : load request; accepted when load_ready is high
//   load_ready              : high in IDLE and HOLD (decoded from state only)
//   start, halt             : run control; halt wins over start
//   auto_reload             : at expiry, 1 = reload and continue, 0 = stop
//   tick_en                 : count enable
//   prescale                : (macro only) prescaler compare value
//   count                   : current count (registered)
//   busy                    : high while in RUN (decoded from state register)
//   expire                  : registered one-cycle pulse on the terminal tick
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH
`ifdef DOWN_TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [WIDTH-1:0]      load_value,
  output logic                  load_ready,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  auto_reload,
  input  logic                  tick_en,
`ifdef DOWN_TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expire
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;
  logic             load_acc;
  logic             eff_tick;

  assign load_ready = (state_q != ST_RUN);
  assign load_acc   = load_valid && load_ready;

`ifdef DOWN_TIMER_PRESCALE_EN
  logic run_active;
  logic exit_run;

  // Halt blocks counting, so the prescaler must not advance on a halt cycle.
  assign run_active = (state_q == ST_RUN) && !halt;
  assign exit_run   = (state_q == ST_RUN) && (state_d != ST_RUN);

  down_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run_active),
    .clear    (load_acc || exit_run),
    .tick_en  (tick_en),
    .prescale (prescale),
    .tick_out (eff_tick)
  );
`else
  assign eff_tick = tick_en;
`endif

  // Next-state, count and expiry logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (start && !halt) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HOLD;
        end else if (eff_tick) begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            expire_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loads only occur outside RUN, so they never collide with a decrement.
    if (load_acc) begin
      count_d  = load_value;
      reload_d = load_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end

  assign count  = count_q;
  assign busy   = (state_q == ST_RUN);
  assign expire = expire_q;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
module tb_down_timer;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             start;
  logic             halt;
  logic             auto_reload;
  logic             tick_en;
`ifdef DOWN_TIMER_PRESCALE_EN
  logic [3:0]       prescale;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expire;

  int n_total = 0;
  int n_bad   = 0;

  down_timer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_value  (load_value),
    .load_ready  (load_ready),
    .start       (start),
    .halt        (halt),
    .auto_reload (auto_reload),
    .tick_en     (tick_en),
`ifdef DOWN_TIMER_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .busy        (busy),
    .expire      (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    int pulses;
    int budget;

    rst_n = 1'b0; load_valid = 1'b0; load_value = '0; start = 1'b0;
    halt = 1'b0; auto_reload = 1'b0; tick_en = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
    prescale = 4'd0;
`endif
    load_valid = 1'b1; load_value = 8'd99;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_expire", 32'(expire), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // One-shot: load 5, count 5..0, expire after the 6th tick.
    do_load(8'd5);
    check("os_load", 32'(count), 32'd5);
    start = 1'b1; tick_en = 1'b1;
    step();
    start = 1'b0;
    check("os_busy", 32'(busy), 32'd1);
    check("os_entry", 32'(count), 32'd5);
    for (int i = 4; i >= 0; i--) begin
      step();
      check("os_count", 32'(count), 32'(i));
      check("os_noexp", 32'(expire), 32'd0);
    end
    step();
    check("os_expire", 32'(expire), 32'd1);
    check("os_idle", 32'(busy), 32'd0);
    check("os_zero", 32'(count), 32'd0);
    step();
    check("os_pulse1", 32'(expire), 32'd0);
    check("os_hold0", 32'(count), 32'd0);

    // Auto-reload: load 3, period 4, 5 pulses in 20 cycles.
    tick_en = 1'b0; auto_reload = 1'b1;
    do_load(8'd3);
    start = 1'b1; tick_en = 1'b1;
    step();
    start = 1'b0;
    exp_cnt = 3; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      logic exp_e;
      step();
      if (exp_cnt == 0) begin exp_e = 1'b1; exp_cnt = 3; end
      else begin exp_e = 1'b0; exp_cnt--; end
      if (expire) pulses++;
      check("ar_count", 32'(count), 32'(exp_cnt));
      check("ar_expire", 32'(expire), 32'(exp_e));
      check("ar_busy", 32'(busy), 32'd1);
    end
    check("ar_pulses", 32'(pulses), 32'd5);
    auto_reload = 1'b0;
    budget = 10;
    while (busy && budget > 0) begin step(); budget--; end
    check("ar_stop", 32'(busy), 32'd0);

    // Halt/resume: load 10, 4 ticks, halt, reload 2 in HOLD, restart.
    tick_en = 1'b0;
    do_load(8'd10);
    start = 1'b1; tick_en = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("hr_six", 32'(count), 32'd6);
    halt = 1'b1;
    step();
    check("hr_frozen", 32'(count), 32'd6);
    check("hr_ready", 32'(load_ready), 32'd1);
    check("hr_busy", 32'(busy), 32'd0);
    step();
    check("hr_frozen2", 32'(count), 32'd6);
    halt = 1'b0;
    do_load(8'd2);
    check("hr_load", 32'(count), 32'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("hr_resume", 32'(busy), 32'd1);
    step(); check("hr_c1", 32'(count), 32'd1);
    step(); check("hr_c0", 32'(count), 32'd0);
    check("hr_noexp", 32'(expire), 32'd0);
    step();
    check("hr_expire", 32'(expire), 32'd1);
    check("hr_idle", 32'(busy), 32'd0);

    // Boundary: load 0 expires on first tick.
    do_load(8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("b0_busy", 32'(busy), 32'd1);
    step();
    check("b0_expire", 32'(expire), 32'd1);
    check("b0_idle", 32'(busy), 32'd0);

    // Boundary: start+halt in IDLE stays IDLE.
    start = 1'b1; halt = 1'b1;
    step();
    start = 1'b0; halt = 1'b0;
    check("sh_idle", 32'(busy), 32'd0);

    // Boundary: load in RUN is ignored.
    tick_en = 1'b0;
    do_load(8'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    load_valid = 1'b1; load_value = 8'd77;
    check("lr_ready", 32'(load_ready), 32'd0);
    step();
    load_valid = 1'b0;
    check("lr_ignored", 32'(count), 32'd5);
    halt = 1'b1;
    step();
    halt = 1'b0;

    // Reset mid-RUN: load 200, 50 ticks, async reset between edges.
    do_load(8'd200);
    start = 1'b1; tick_en = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    check("mr_count", 32'(count), 32'd150);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rcount", 32'(count), 32'd0);
    check("mr_rbusy", 32'(busy), 32'd0);
    check("mr_rexpire", 32'(expire), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin step(); if (expire || busy) pulses++; end
    check("mr_quiet", 32'(pulses), 32'd0);

`ifdef DOWN_TIMER_PRESCALE_EN
    // Prescale 3, load 2: decrement every 4 cycles, expire 12 cycles after start.
    tick_en = 1'b0; prescale = 4'd3;
    do_load(8'd2);
    start = 1'b1; tick_en = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("ps_count", 32'(count), (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0);
      check("ps_expire", 32'(expire), (k == 12) ? 32'd1 : 32'd0);
    end
    check("ps_idle", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_down_timer
